// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer, one result bit per clock.
//   Multiply uses shift-and-add (low word only), divide uses restoring subtraction.
//   Optional feature macro: MULDIV_SDIV_EN enables signed divide on op 4'b0110.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, op, a, b   request pulse, ALUControl opcode, operands (latched on accept)
//   busy, done        busy from accept through done; done is a one-cycle pulse
//   result, flags     low product word or quotient; flags = {N, Z, C, V}
//   divzero, err      divide with b == 0; unsupported opcode
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             divzero,
    output logic             err
);

    localparam int unsigned CW = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [3:0] OP_UMUL = 4'b0100;
    localparam logic [3:0] OP_SMUL = 4'b0101;
    localparam logic [3:0] OP_UDIV = 4'b0111;
`ifdef MULDIV_SDIV_EN
    localparam logic [3:0] OP_SDIV = 4'b0110;
`endif

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             run_mul;
    // acc: product accumulator or partial remainder; x: multiplicand or quotient/dividend; y: multiplier or divisor
    logic [WIDTH-1:0] acc, x, y;
    logic [WIDTH-1:0] acc_step, x_step, y_step, res_step;
    logic [WIDTH:0]   rem_sh;
    logic             is_mul, is_div, last_iter;
`ifdef MULDIV_SDIV_EN
    logic             is_sdiv, neg;
    logic [WIDTH-1:0] a_mag, b_mag;
`endif

    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0), 2'b00};
    endfunction

    // Opcode decode of the request presented in IDLE
    always_comb begin
        is_mul = (op == OP_UMUL) || (op == OP_SMUL);
`ifdef MULDIV_SDIV_EN
        is_sdiv = (op == OP_SDIV);
        is_div  = (op == OP_UDIV) || is_sdiv;
`else
        is_div  = (op == OP_UDIV);
`endif
    end

`ifdef MULDIV_SDIV_EN
    // Signed divide runs on magnitudes; the most negative value maps to itself, which is correct unsigned
    assign a_mag = (is_sdiv && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_sdiv && b[WIDTH-1]) ? -b : b;
`endif

    assign last_iter = (cnt == CW'(WIDTH - 1));

    // One iteration of the active algorithm
    always_comb begin
        rem_sh   = {acc, x[WIDTH-1]};
        acc_step = acc;
        x_step   = x;
        y_step   = y;
        res_step = '0;
        if (run_mul) begin
            acc_step = acc + (y[0] ? x : '0);
            x_step   = x << 1;
            y_step   = y >> 1;
            res_step = acc_step;
        end else begin
            x_step   = {x[WIDTH-2:0], 1'b0};
            // Remainder stays below the divisor, so its top bit is always zero between steps
            acc_step = rem_sh[WIDTH-1:0];
            if (rem_sh >= {1'b0, y}) begin
                acc_step  = WIDTH'(rem_sh - {1'b0, y});
                x_step[0] = 1'b1;
            end
            res_step = x_step;
`ifdef MULDIV_SDIV_EN
            if (neg) begin
                res_step = -x_step;
            end
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul || (is_div && (b != '0))) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flags   <= 4'b0100;
            divzero <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            run_mul <= 1'b0;
            acc     <= '0;
            x       <= '0;
            y       <= '0;
`ifdef MULDIV_SDIV_EN
            neg     <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        acc     <= '0;
                        divzero <= 1'b0;
                        err     <= 1'b0;
                        run_mul <= is_mul;
                        if (is_mul) begin
                            x <= a;
                            y <= b;
                        end else if (is_div) begin
`ifdef MULDIV_SDIV_EN
                            x   <= a_mag;
                            y   <= b_mag;
                            neg <= is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
                            x <= a;
                            y <= b;
`endif
                            if (b == '0) begin
                                result  <= '1;
                                flags   <= nzcv({WIDTH{1'b1}});
                                divzero <= 1'b1;
                            end
                        end else begin
                            result <= '0;
                            flags  <= nzcv('0);
                            err    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    x   <= x_step;
                    y   <= y_step;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        result <= res_step;
                        flags  <= nzcv(res_step);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table, randomized operations against a plain-arithmetic
// model, and hand-written sequences for start-while-busy and reset-mid-operation.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        divzero;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flags   (flags),
        .divzero (divzero),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        dz;
        logic        er;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_flags(input logic [31:0] r);
        return {r[31], (r == 32'd0), 2'b00};
    endfunction

    // Reference: what the operation means arithmetically, plus its documented latency
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic dz, output logic er,
                                  output int lat);
        r = 32'd0; dz = 1'b0; er = 1'b0; lat = 33;
        case (o)
            4'b0100, 4'b0101: r = x * y;
            4'b0111: begin
                if (y == 32'd0) begin r = 32'hFFFF_FFFF; dz = 1'b1; lat = 1; end
                else r = x / y;
            end
`ifdef MULDIV_SDIV_EN
            4'b0110: begin
                longint sx, sy, q;
                if (y == 32'd0) begin r = 32'hFFFF_FFFF; dz = 1'b1; lat = 1; end
                else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q  = sx / sy;
                    r  = q[31:0];
                end
            end
`endif
            default: begin er = 1'b1; lat = 1; end
        endcase
    endfunction

    // Issue one operation, scramble inputs while it runs, and capture the done-cycle outputs
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [3:0] f, output logic dz,
                          output logic er, output int lat, output int proto_bad);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        proto_bad = 0;
        while (!done && lat < 60) begin
            if (busy !== 1'b1) proto_bad++;
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b1) proto_bad++;
        r = result; f = flags; dz = divzero; er = err;
        @(posedge clk); #1;
        if (done !== 1'b0 || busy !== 1'b0) proto_bad++;
        if (result !== r || flags !== f) proto_bad++;
    endtask

    task automatic check_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] er_res,
                            input logic [3:0] er_fl, input logic er_dz, input logic er_er,
                            input int er_lat);
        logic [31:0] r;
        logic [3:0]  f;
        logic        dz, e;
        int          lat, pb;
        run_op(o, x, y, r, f, dz, e, lat, pb);
        check({tag, " result"}, r, er_res);
        check({tag, " flags"}, 32'(f), 32'(er_fl));
        check({tag, " divzero"}, 32'(dz), 32'(er_dz));
        check({tag, " err"}, 32'(e), 32'(er_er));
        check({tag, " latency"}, 32'(lat), 32'(er_lat));
        check({tag, " busy/done/hold"}, 32'(pb), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;

        vecs.push_back('{4'b0100, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 4'b0000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0101, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 4'b1000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0100, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 4'b1000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0111, 32'd100,       32'd7,         32'd14,        4'b0000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0111, 32'd5,         32'd9,         32'd0,         4'b0100, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0111, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0111, 32'd42,        32'd0,         32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0100, 32'd2,         32'd3,         32'd6,         4'b0000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0000, 32'd12,        32'd34,        32'd0,         4'b0100, 1'b0, 1'b1, 1});
`ifdef MULDIV_SDIV_EN
        vecs.push_back('{4'b0110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 4'b1000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1000, 1'b0, 1'b0, 33});
        vecs.push_back('{4'b0110, 32'd9,         32'd0,         32'hFFFF_FFFF, 4'b1000, 1'b1, 1'b0, 1});
`else
        vecs.push_back('{4'b0110, 32'hFFFF_FFF9, 32'd2,         32'd0,         4'b0100, 1'b0, 1'b1, 1});
`endif

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy",    32'(busy),    32'd0);
        check("reset done",    32'(done),    32'd0);
        check("reset result",  result,       32'd0);
        check("reset flags",   32'(flags),   32'h4);
        check("reset divzero", 32'(divzero), 32'd0);
        check("reset err",     32'(err),     32'd0);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                     vecs[i].fl, vecs[i].dz, vecs[i].er, vecs[i].lat);
        end

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  o;
            logic [31:0] x, y, r;
            logic        dz, e;
            int          lat, sel;
            sel = $urandom_range(0, 9);
            if (sel < 2)      o = 4'b0100;
            else if (sel < 4) o = 4'b0101;
            else if (sel < 6) o = 4'b0111;
            else if (sel < 8) o = 4'b0110;
            else              o = 4'($urandom);
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1, 2:    y = 32'($urandom_range(1, 20));
                3:       y = -32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            model(o, x, y, r, dz, e, lat);
            check_op($sformatf("rand%0d op%h %h,%h", i, o, x, y), o, x, y, r, exp_flags(r), dz, e, lat);
        end

        // start during RUN and during the done cycle is ignored and not queued
        begin
            int ndone, done_at;
            logic [31:0] first_res;
            logic        busy_late;
            ndone = 0; done_at = 0; first_res = 32'd0; busy_late = 1'b1;
            @(negedge clk);
            op = 4'b0100; a = 32'd3; b = 32'd5; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 1; k <= 45; k++) begin
                if (done) begin
                    ndone++;
                    if (done_at == 0) begin done_at = k; first_res = result; end
                end
                if (k == 40) busy_late = busy;
                @(negedge clk);
                start = (k == 5 || k == 33);
                op = 4'b0111; a = 32'd99; b = 32'd4;
                @(posedge clk); #1;
            end
            start = 1'b0;
            check("ignore-start done count", 32'(ndone), 32'd1);
            check("ignore-start latency", 32'(done_at), 32'd33);
            check("ignore-start result", first_res, 32'd15);
            check("ignore-start not queued", 32'(busy_late), 32'd0);
        end

        // Reset mid-RUN aborts with no done, and wins over a simultaneous start
        begin
            int ndone;
            logic busy_seen;
            ndone = 0; busy_seen = 1'b0;
            @(negedge clk);
            op = 4'b0100; a = 32'd7; b = 32'd9; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            @(negedge clk);
            check("pre-reset busy", 32'(busy), 32'd1);
            reset = 1'b1; start = 1'b1; op = 4'b0100;
            @(posedge clk); #1;
            check("mid-reset busy",   32'(busy),   32'd0);
            check("mid-reset done",   32'(done),   32'd0);
            check("mid-reset result", result,      32'd0);
            check("mid-reset flags",  32'(flags),  32'h4);
            @(negedge clk);
            reset = 1'b0; start = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done) ndone++;
                if (busy) busy_seen = 1'b1;
            end
            check("post-reset done count", 32'(ndone), 32'd0);
            check("post-reset busy", 32'(busy_seen), 32'd0);
        end

        // Normal operation resumes after the abort
        check_op("after-reset umul", 4'b0101, 32'd11, 32'd13, 32'd143, 4'b0000, 1'b0, 1'b0, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
